// File: rtl/vga_pkg.sv
// Timing constants and shared types for the VGA raster path.
// Default constants describe 640x480@60 Hz. Derived totals and sync
// windows are given so that mappers and checkers can reuse them.
// coord_t is the 10-bit coordinate carried on DrawX/DrawY.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;
  localparam int unsigned DEF_PIX_DIV   = 2;

  function automatic int unsigned axis_total(input int unsigned visible,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return visible + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Inclusive sync windows: 656..751 horizontally, 490..491 vertically.
  localparam int unsigned H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int unsigned V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a 0..TOTAL-1 counter with its combinational decodes.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         advance the count by one (wraps to 0 after TOTAL-1)
//   count      current position (register output)
//   wrap       count is at TOTAL-1; the next enabled step returns to 0
//   sync_n     low while count is inside the sync window
//   visible    count is inside the active region
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FP      = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BP      = 48
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output logic   wrap,
  output logic   sync_n,
  output logic   visible
);

  localparam int unsigned TOTAL      = axis_total(VISIBLE, FP, SYNC, BP);
  localparam int unsigned SYNC_START = VISIBLE + FP;
  // Exclusive end, so an empty window (SYNC=0) decodes as never-in-sync.
  localparam int unsigned SYNC_STOP  = SYNC_START + SYNC;
  localparam coord_t      LAST       = coord_t'(TOTAL - 1);

  if (TOTAL > 1024 || TOTAL < 2) begin : g_total_check
    $error("vga_axis_counter: TOTAL=%0d does not fit a 10-bit counter", TOTAL);
  end

  // Decodes are done on a 32-bit copy so a window end of exactly 1024
  // cannot alias back to 0.
  logic [31:0] count_w;
  assign count_w = 32'(count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + coord_t'(1);
    end
  end

  assign wrap    = (count == LAST);
  assign sync_n  = !((count_w >= SYNC_START) && (count_w < SYNC_STOP));
  assign visible = (count_w < VISIBLE);

endmodule

// File: rtl/vga_scanner.sv
// Raster timing generator and pixel output stage for the VGA DAC.
// A pixel divider produces pixel_en once every PIX_DIV clocks; the H and
// V axis counters advance on it. Stage 0 is the combinational decode of
// the counters (visible / sync windows) together with the mapper colour
// for DrawX/DrawY; stage 1 registers all pins on pixel_en so colour,
// syncs and blank stay aligned, one pixel period behind the coordinates.
// Ports:
//   Clk, Reset             clock, asynchronous active-high reset
//   Red, Green, Blue       mapper colour for the current DrawX/DrawY
//   DrawX, DrawY           current coordinate (register outputs)
//   pixel_en               strobe, high one Clk per pixel period
//   frame_start            one-Clk pulse after the (799,524)->(0,0) wrap
//   VGA_R, VGA_G, VGA_B    blanked colour
//   VGA_HS, VGA_VS         active-low syncs
//   VGA_BLANK_N            high during the visible region
module vga_scanner
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned PIX_DIV   = DEF_PIX_DIV
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red,
  input  logic [7:0] Green,
  input  logic [7:0] Blue,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       pixel_en,
  output logic       frame_start,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N
);

  if (PIX_DIV < 1) begin : g_div_check
    $error("vga_scanner: PIX_DIV must be at least 1");
  end

  localparam int unsigned     DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div;
  logic h_wrap, v_wrap;
  logic hs0, vs0;
  logic h_vis, v_vis, vis0;

  // Pixel divider. With PIX_DIV=1 it sits at 0 and pixel_en is constant 1.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign pixel_en = (div == DIV_LAST);

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP)
  ) u_h (
    .clk     (Clk),
    .rst     (Reset),
    .en      (pixel_en),
    .count   (DrawX),
    .wrap    (h_wrap),
    .sync_n  (hs0),
    .visible (h_vis)
  );

  // V steps on the same edge that wraps H back to 0.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP)
  ) u_v (
    .clk     (Clk),
    .rst     (Reset),
    .en      (pixel_en & h_wrap),
    .count   (DrawY),
    .wrap    (v_wrap),
    .sync_n  (vs0),
    .visible (v_vis)
  );

  assign vis0 = h_vis & v_vis;

  // Stage 1: the mapper answer for the coordinate being left behind is
  // captured on the same edge the counters move on.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pixel_en) begin
      VGA_R       <= vis0 ? Red   : 8'h00;
      VGA_G       <= vis0 ? Green : 8'h00;
      VGA_B       <= vis0 ? Blue  : 8'h00;
      VGA_HS      <= hs0;
      VGA_VS      <= vs0;
      VGA_BLANK_N <= vis0;
    end
  end

  // High for the single Clk after the edge that takes (last,last) to (0,0).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pixel_en & h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_scanner.sv
// Bench for vga_scanner. Two instances with a reduced raster (30x17
// totals) so whole frames fit in a short run: dut with PIX_DIV=2 and
// dut1 with PIX_DIV=1. The reference model derives every output from the
// number of clock edges since reset release using plain arithmetic.
module tb_vga_scanner;

  localparam int unsigned HV = 16, HFP = 4, HSW = 6, HBP = 4;
  localparam int unsigned VV = 10, VFP = 2, VSW = 2, VBP = 3;
  localparam int unsigned HT = HV + HFP + HSW + HBP;   // 30
  localparam int unsigned VT = VV + VFP + VSW + VBP;   // 17

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Edges seen since reset release; the model is a function of this.
  int unsigned n;
  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // ---------------- mappers ----------------
  logic [7:0] lut [0:255];

  logic [9:0] dx0, dy0, dx1, dy1;
  logic [7:0] red0, grn0, red1, grn1;
  logic       pe0, fs0, hs0, vs0, bl0, pe1, fs1, hs1, vs1, bl1;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic [9:0] gi0, gi1;

  assign red0 = dx0[7:0];
  assign gi0  = dx0 + 10'd7 * dy0;
  assign grn0 = lut[gi0[7:0]];
  assign red1 = dx1[7:0];
  assign gi1  = dx1 + 10'd7 * dy1;
  assign grn1 = lut[gi1[7:0]];

  vga_scanner #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIX_DIV(2)
  ) dut (
    .Clk(clk), .Reset(rst), .Red(red0), .Green(grn0), .Blue(8'hFF),
    .DrawX(dx0), .DrawY(dy0), .pixel_en(pe0), .frame_start(fs0),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0),
    .VGA_HS(hs0), .VGA_VS(vs0), .VGA_BLANK_N(bl0)
  );

  vga_scanner #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIX_DIV(1)
  ) dut1 (
    .Clk(clk), .Reset(rst), .Red(red1), .Green(grn1), .Blue(8'hFF),
    .DrawX(dx1), .DrawY(dy1), .pixel_en(pe1), .frame_start(fs1),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLANK_N(bl1)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pe;
    logic        fs;
    logic [23:0] rgb;
    logic [2:0]  sync;   // {HS, VS, BLANK_N}
  } exp_t;

  // n edges at p clocks per pixel means n/p pixels have elapsed. The pins
  // show the pixel before the current one; before any pixel they hold
  // their reset values.
  function automatic exp_t model(input int unsigned edges, input int unsigned p);
    exp_t e;
    int unsigned pix, q, x, y;
    bit vis, hs, vs;
    pix  = edges / p;
    e.x  = 10'(pix % HT);
    e.y  = 10'((pix / HT) % VT);
    e.pe = ((edges % p) == p - 1);
    e.fs = (edges > 0) && ((edges % p) == 0) && ((pix % (HT * VT)) == 0);
    if (pix == 0) begin
      e.rgb  = 24'h0;
      e.sync = 3'b110;
    end else begin
      q   = pix - 1;
      x   = q % HT;
      y   = (q / HT) % VT;
      vis = (x < HV) && (y < VV);
      hs  = !((x >= HV + HFP) && (x < HV + HFP + HSW));
      vs  = !((y >= VV + VFP) && (y < VV + VFP + VSW));
      e.rgb  = vis ? {8'(x), lut[8'((x + 7 * y) % 256)], 8'hFF} : 24'h0;
      e.sync = {hs, vs, vis};
    end
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({dx0, dy0} !== 20'h0) begin
      failures++; $display("FAIL reset_xy got %h/%h want 0/0", dx0, dy0);
    end
    checks++;
    if ({r0, g0, b0} !== 24'h0) begin
      failures++; $display("FAIL reset_rgb got %h want 000000", {r0, g0, b0});
    end
    checks++;
    if ({hs0, vs0, bl0, fs0} !== 4'b1100) begin
      failures++; $display("FAIL reset_pins got hs%b vs%b bl%b fs%b want 1 1 0 0", hs0, vs0, bl0, fs0);
    end
    checks++;
    if ({pe0, pe1} !== 2'b01) begin
      failures++; $display("FAIL reset_pixel_en got %b%b want 01", pe0, pe1);
    end
  endtask

  // Compare every output of both instances against the model each clock.
  task automatic test_free_run(input int cycles);
    exp_t e0, e1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      e0 = model(n, 2);
      e1 = model(n, 1);
      checks++;
      if ({dx0, dy0} !== {e0.x, e0.y}) begin
        failures++; $display("FAIL div2_xy n=%0d got %0d,%0d want %0d,%0d", n, dx0, dy0, e0.x, e0.y);
      end
      checks++;
      if ({pe0, fs0} !== {e0.pe, e0.fs}) begin
        failures++; $display("FAIL div2_pe_fs n=%0d got %b%b want %b%b", n, pe0, fs0, e0.pe, e0.fs);
      end
      checks++;
      if ({r0, g0, b0} !== e0.rgb) begin
        failures++; $display("FAIL div2_rgb n=%0d got %h want %h", n, {r0, g0, b0}, e0.rgb);
      end
      checks++;
      if ({hs0, vs0, bl0} !== e0.sync) begin
        failures++; $display("FAIL div2_sync n=%0d got %b want %b", n, {hs0, vs0, bl0}, e0.sync);
      end
      checks++;
      if ({dx1, dy1} !== {e1.x, e1.y}) begin
        failures++; $display("FAIL div1_xy n=%0d got %0d,%0d want %0d,%0d", n, dx1, dy1, e1.x, e1.y);
      end
      checks++;
      if ({pe1, fs1} !== {e1.pe, e1.fs}) begin
        failures++; $display("FAIL div1_pe_fs n=%0d got %b%b want %b%b", n, pe1, fs1, e1.pe, e1.fs);
      end
      checks++;
      if ({r1, g1, b1} !== e1.rgb) begin
        failures++; $display("FAIL div1_rgb n=%0d got %h want %h", n, {r1, g1, b1}, e1.rgb);
      end
      checks++;
      if ({hs1, vs1, bl1} !== e1.sync) begin
        failures++; $display("FAIL div1_sync n=%0d got %b want %b", n, {hs1, vs1, bl1}, e1.sync);
      end
    end
  endtask

  // HS width, line period and the DrawX at which HS falls.
  task automatic test_hsync();
    int t, w, per;
    logic [9:0] x_at_fall;
    t = 0;
    while (!(hs0 === 1'b0) && t < 200) begin @(negedge clk); t++; end
    while (!(hs0 === 1'b1) && t < 400) begin @(negedge clk); t++; end
    while (!(hs0 === 1'b0) && t < 600) begin @(negedge clk); t++; end
    checks++;
    if (t >= 600) begin
      failures++; $display("FAIL hs_timeout got no HS fall want one within 600 clk");
      return;
    end
    x_at_fall = dx0;
    checks++;
    if (x_at_fall !== 10'(HV + HFP + 1)) begin
      failures++; $display("FAIL hs_fall_x got %0d want %0d", x_at_fall, HV + HFP + 1);
    end
    w = 0;
    while (hs0 === 1'b0 && w < 200) begin @(negedge clk); w++; end
    checks++;
    if (w != HSW * 2) begin
      failures++; $display("FAIL hs_width got %0d want %0d", w, HSW * 2);
    end
    per = w;
    while (hs0 === 1'b1 && per < 400) begin @(negedge clk); per++; end
    checks++;
    if (per != HT * 2) begin
      failures++; $display("FAIL line_period got %0d want %0d", per, HT * 2);
    end
    // PIX_DIV=1 instance: width and period in one pass.
    t = 0;
    while (!(hs1 === 1'b1) && t < 200) begin @(negedge clk); t++; end
    while (!(hs1 === 1'b0) && t < 400) begin @(negedge clk); t++; end
    w = 0;
    while (hs1 === 1'b0 && w < 200) begin @(negedge clk); w++; end
    per = w;
    while (hs1 === 1'b1 && per < 400) begin @(negedge clk); per++; end
    checks++;
    if (w != HSW || per != HT) begin
      failures++; $display("FAIL div1_hs got width %0d period %0d want %0d %0d", w, per, HSW, HT);
    end
  endtask

  // frame_start spacing and width, VS width and start line.
  task automatic test_frame();
    int t, per, w;
    t = 0;
    while (!(fs0 === 1'b1) && t < 2200) begin @(negedge clk); t++; end
    checks++;
    if (t >= 2200) begin
      failures++; $display("FAIL fs_timeout got no frame_start want one within 2200 clk");
      return;
    end
    @(negedge clk);
    checks++;
    if (fs0 !== 1'b0) begin
      failures++; $display("FAIL fs_width got %b one clk later want 0", fs0);
    end
    per = 1;
    while (!(fs0 === 1'b1) && per < 2200) begin @(negedge clk); per++; end
    checks++;
    if (per != HT * VT * 2) begin
      failures++; $display("FAIL frame_period got %0d want %0d", per, HT * VT * 2);
    end
    t = 0;
    while (!(vs0 === 1'b0) && t < 2200) begin @(negedge clk); t++; end
    checks++;
    if (dy0 !== 10'(VV + VFP)) begin
      failures++; $display("FAIL vs_fall_y got %0d want %0d", dy0, VV + VFP);
    end
    w = 0;
    while (vs0 === 1'b0 && w < 2200) begin @(negedge clk); w++; end
    checks++;
    if (w != VSW * HT * 2) begin
      failures++; $display("FAIL vs_width got %0d want %0d", w, VSW * HT * 2);
    end
    t = 0;
    while (!(fs1 === 1'b1) && t < 1200) begin @(negedge clk); t++; end
    @(negedge clk);
    per = 1;
    while (!(fs1 === 1'b1) && per < 1200) begin @(negedge clk); per++; end
    checks++;
    if (per != HT * VT) begin
      failures++; $display("FAIL div1_frame_period got %0d want %0d", per, HT * VT);
    end
  endtask

  // Asynchronous reset at a random point, then restart timing.
  task automatic test_mid_reset();
    test_free_run($urandom_range(100, 900));
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dx0, dy0, dx1, dy1} !== 40'h0) begin
      failures++; $display("FAIL midrst_xy got %0d,%0d %0d,%0d want zeros", dx0, dy0, dx1, dy1);
    end
    checks++;
    if ({r0, g0, b0, hs0, vs0, bl0, fs0, pe0} !== {24'h0, 5'b11000}) begin
      failures++; $display("FAIL midrst_pins got rgb %h hs%b vs%b bl%b fs%b pe%b want reset values",
                           {r0, g0, b0}, hs0, vs0, bl0, fs0, pe0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({pe0, dx0} !== {1'b1, 10'd0}) begin
      failures++; $display("FAIL midrst_first_pe got pe%b x%0d want pe1 x0", pe0, dx0);
    end
    @(negedge clk);
    checks++;
    if (dx0 !== 10'd1) begin
      failures++; $display("FAIL midrst_first_x got %0d want 1", dx0);
    end
    test_free_run(200);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    rst = 1'b0;
    test_free_run(2200);
    test_hsync();
    test_frame();
    for (int k = 0; k < 3; k++) test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
